// File: rtl/dso_regbank_pkg.sv
// Shared defaults and helpers for the double-buffered register bank.
// Imported by the storage cell and the top level.
package dso_regbank_pkg;

    localparam int DEF_N_REGS = 8;
    localparam int DEF_DW     = 8;
    localparam int DEF_AW     = 3;

    // Smallest address width that can reach every register.
    function automatic int aw_for(input int n_regs);
        int w;
        w = 1;
        while ((1 << w) < n_regs) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dso_regbank_cell.sv
// One register: shadow copy with masked write, active copy loaded on
// commit, or on every write when the register is immediate.
module dso_regbank_cell
    import dso_regbank_pkg::*;
#(
    parameter int            DW  = DEF_DW,
    parameter logic [DW-1:0] RST = '0,
    parameter bit            IMM = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [DW-1:0] wr_data,
    input  logic [DW-1:0] wr_mask,
    input  logic          commit,
    output logic [DW-1:0] shadow,
    output logic [DW-1:0] active
);

    logic [DW-1:0] shadow_nxt;

    // Post-write shadow value; commit and immediate load both use it.
    always_comb begin
        shadow_nxt = shadow;
        if (wr) begin
            shadow_nxt = (shadow & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    // Shadow/active storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= RST;
            active <= RST;
        end else begin
            shadow <= shadow_nxt;
            if (commit || (IMM && wr)) begin
                active <= shadow_nxt;
            end
        end
    end

endmodule

// File: rtl/dso_regbank.sv
// Double-buffered register bank: write decode, dirty tracking,
// registered read port and address error flag.
module dso_regbank
    import dso_regbank_pkg::*;
#(
    parameter int                     N_REGS   = DEF_N_REGS,
    parameter int                     DW       = DEF_DW,
    parameter int                     AW       = DEF_AW,
    parameter logic [N_REGS*DW-1:0]   RST_VAL  = '0,
    parameter logic [N_REGS-1:0]      IMM_MASK = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic [DW-1:0]        wr_mask,
    input  logic                 commit,
    input  logic                 rd_req,
    input  logic [AW-1:0]        rd_addr,
    input  logic                 rd_shadow,
    output logic                 rd_valid,
    output logic [DW-1:0]        rd_data,
    output logic                 addr_err,
    output logic [N_REGS-1:0]    dirty,
    output logic [N_REGS*DW-1:0] regs_out
);

    logic [DW-1:0]     sh  [N_REGS];
    logic [DW-1:0]     act [N_REGS];
    logic [N_REGS-1:0] wr_hit;
    logic [DW-1:0]     rd_sel;
    logic              wr_oor;
    logic              rd_oor;

    assign wr_oor = wr_en && (int'(wr_addr) >= N_REGS);
    assign rd_oor = rd_req && (int'(rd_addr) >= N_REGS);

    for (genvar i = 0; i < N_REGS; i++) begin : g_reg
        assign wr_hit[i] = wr_en && (int'(wr_addr) == i);

        dso_regbank_cell #(
            .DW  (DW),
            .RST (RST_VAL[i*DW +: DW]),
            .IMM (IMM_MASK[i])
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .wr      (wr_hit[i]),
            .wr_data (wr_data),
            .wr_mask (wr_mask),
            .commit  (commit),
            .shadow  (sh[i]),
            .active  (act[i])
        );

        assign regs_out[i*DW +: DW] = act[i];
    end

    // Read mux; out-of-range addresses fall through to zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (int'(rd_addr) == i) begin
                rd_sel = rd_shadow ? sh[i] : act[i];
            end
        end
    end

    // Dirty bits: set by non-immediate writes, cleared by commit.
    always_ff @(posedge clk) begin
        if (rst || commit) begin
            dirty <= '0;
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                if (wr_hit[i] && !IMM_MASK[i]) begin
                    dirty[i] <= 1'b1;
                end
            end
        end
    end

    // Registered read port; data holds between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= rd_sel;
            end
        end
    end

    // One-cycle error pulse for out-of-range access on either port.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= wr_oor || rd_oor;
        end
    end

endmodule
